// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled 8N1 UART receiver with valid/ready delivery, framing and overrun flags
`timescale 1ns/1ps
module uart_rx_os #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    localparam int OS_DIV  = CLK_FREQ / (BAUD * 16),
    localparam int CW      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        state, state_n;
    logic          s1, rx_s;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [3:0]    scnt, scnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    sh, sh_n;
    logic          done, bad, load;

    assign tick    = cnt == CW'(OS_DIV - 1);
    assign rx_busy = state != IDLE;
    // A completed byte is taken only if the slot is empty or being drained this edge
    assign load    = done & (~rx_valid | rx_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b1;
            rx_s      <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
            scnt      <= '0;
            bidx      <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            s1        <= rx;
            rx_s      <= s1;
            cnt       <= tick ? '0 : cnt + CW'(1);
            state     <= state_n;
            scnt      <= scnt_n;
            bidx      <= bidx_n;
            sh        <= sh_n;
            rx_data   <= load ? sh : rx_data;
            rx_valid  <= load | (rx_valid & ~rx_ready);
            frame_err <= bad;
            overrun   <= done & rx_valid & ~rx_ready;
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bidx_n  = bidx;
        sh_n    = sh;
        done    = 1'b0;
        bad     = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        scnt_n  = '0;
                    end
                end
                START: begin
                    if (scnt == 4'd7) begin
                        state_n = rx_s ? IDLE : DATA;
                        scnt_n  = '0;
                        bidx_n  = '0;
                    end else
                        scnt_n = scnt + 4'd1;
                end
                DATA: begin
                    if (scnt == 4'd15) begin
                        sh_n[bidx] = rx_s;
                        scnt_n     = '0;
                        bidx_n     = bidx + 3'd1;
                        state_n    = (bidx == 3'd7) ? STOP : DATA;
                    end else
                        scnt_n = scnt + 4'd1;
                end
                STOP: begin
                    if (scnt == 4'd15) begin
                        scnt_n  = '0;
                        done    = rx_s;
                        bad     = ~rx_s;
                        state_n = rx_s ? IDLE : WAIT_HI;
                    end else
                        scnt_n = scnt + 4'd1;
                end
                WAIT_HI: state_n = rx_s ? IDLE : WAIT_HI;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed table, corner-case sequences and randomized frames against a byte-queue model
`timescale 1ns/1ps
module tb_uart_rx_os;
    localparam int BIT = 160;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_v;
        int         exp_f;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         n_ferr = 0;
    int         n_ovr = 0;
    logic       pv = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_os #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );

    // A byte is newly presented when valid rises or stays high across an accepting edge
    always @(posedge clk) begin
        #1;
        if (rx_valid && (!pv || rx_ready)) got_q.push_back(rx_data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        pv = rx_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear();
        got_q.delete();
        n_ferr = 0;
        n_ovr = 0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[6];
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic       ok;
        int         exp_f, t0, t1, d_cal, n;

        tbl[0] = '{8'hA5, 1'b1, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 1, 0};
        tbl[2] = '{8'hFF, 1'b1, 1, 0};
        tbl[3] = '{8'h3C, 1'b0, 0, 1};
        tbl[4] = '{8'h81, 1'b1, 1, 0};
        tbl[5] = '{8'h5A, 1'b0, 0, 1};

        repeat (3) @(negedge clk);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", rx_busy, 0);
        do_reset();

        rx_ready = 1'b1;
        foreach (tbl[k]) begin
            clear();
            send_byte(tbl[k].d, tbl[k].stop);
            idle(100);
            chk($sformatf("tbl%0d_count", k), got_q.size(), tbl[k].exp_v);
            if (tbl[k].exp_v == 1 && got_q.size() > 0) chk($sformatf("tbl%0d_data", k), got_q[0], tbl[k].d);
            chk($sformatf("tbl%0d_ferr", k), n_ferr, tbl[k].exp_f);
            chk($sformatf("tbl%0d_ovr", k), n_ovr, 0);
            chk($sformatf("tbl%0d_valid_drop", k), rx_valid, 0);
            chk($sformatf("tbl%0d_busy", k), rx_busy, 0);
        end

        clear();
        rx = 1'b0;
        repeat (35) @(negedge clk);
        chk("glitch_busy_seen", rx_busy, 1);
        repeat (5) @(negedge clk);
        idle(300);
        chk("glitch_count", got_q.size(), 0);
        chk("glitch_ferr", n_ferr, 0);
        chk("glitch_busy", rx_busy, 0);

        clear();
        send_byte(8'h3C, 1'b0);
        repeat (400) @(negedge clk);
        chk("stuck_busy", rx_busy, 1);
        chk("stuck_ferr", n_ferr, 1);
        chk("stuck_count", got_q.size(), 0);
        idle(60);
        chk("stuck_busy_release", rx_busy, 0);

        clear();
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(100);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_pulse", n_ovr, 1);
        chk("ovr_ferr", n_ferr, 0);
        chk("ovr_count", got_q.size(), 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("ovr_consumed", rx_valid, 0);

        // Measure the start-to-delivery distance, then hit that exact edge with rx_ready
        do_reset();
        rx_ready = 1'b1;
        d_cal = 0;
        t0 = cyc;
        fork
            begin
                send_byte(8'h5A, 1'b1);
                idle(100);
            end
            for (int k = 0; k < 2500 && d_cal == 0; k++) begin
                @(negedge clk);
                if (rx_valid) d_cal = cyc - t0;
            end
        join
        chk("calib_seen", d_cal > 0, 1);
        do_reset();
        rx_ready = 1'b0;
        send_byte(8'h55, 1'b1);
        t1 = cyc;
        fork
            send_byte(8'hAA, 1'b1);
            begin
                repeat (d_cal - 1) @(negedge clk);
                chk("same_pre_data", rx_data, 8'h55);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                chk("same_data", rx_data, 8'hAA);
                chk("same_valid", rx_valid, 1);
            end
        join
        idle(100);
        chk("same_ovr", n_ovr, 0);
        chk("same_count", got_q.size(), 2);
        chk("same_cyc", cyc - t1 > d_cal, 1);

        do_reset();
        rx_ready = 1'b0;
        send_byte(8'h77, 1'b1);
        idle(20);
        chk("mid_pre_valid", rx_valid, 1);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                repeat (BIT * 5 + 80) @(negedge clk);
                chk("mid_pre_busy", rx_busy, 1);
                #3 rst_n = 1'b0;
                #1;
                chk("mid_data", rx_data, 0);
                chk("mid_valid", rx_valid, 0);
                chk("mid_busy", rx_busy, 0);
                chk("mid_ferr", frame_err, 0);
                chk("mid_ovr", overrun, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(100);
        clear();
        rx_ready = 1'b1;
        send_byte(8'h0F, 1'b1);
        idle(100);
        chk("post_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("post_data", got_q[0], 8'h0F);
        chk("post_ferr", n_ferr, 0);

        do_reset();
        rx_ready = 1'b1;
        exp_f = 0;
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom);
            ok = $urandom_range(0, 4) != 0;
            send_byte(d, ok);
            if (ok) exp_q.push_back(d);
            else exp_f++;
            idle(ok ? $urandom_range(0, 30) : $urandom_range(40, 80));
        end
        idle(200);
        chk("rnd_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) chk($sformatf("rnd_data%0d", k), got_q[k], exp_q[k]);
        chk("rnd_ferr", n_ferr, exp_f);
        chk("rnd_ovr", n_ovr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
